// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage issue control: counting RAW/WAW scoreboard, stall/bubble/flush sequencing.
// Issue decision is same-cycle combinational; counts/status update at the next edge; stalls hold IF/ID.
module id_scoreboard_ctrl #(
    parameter int MAX_INFLIGHT = 3,
    parameter int STALL_LIMIT  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        ex_flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    output logic        issue,
    output logic        stall_if_id,
    output logic        bubble_id_ex,
    output logic [31:0] pending,
    output logic [31:0] stall_cycles,
    output logic        err_underflow,
    output logic        err_deadlock
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [SW-1:0] SLIMIT  = SW'(STALL_LIMIT);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [31:0][CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]        consec_q, consec_d;
    logic [31:0]          stall_cycles_q, stall_cycles_d;
    logic                 underflow_q, underflow_d;
    logic                 deadlock_q, deadlock_d;

    logic hazard, inc, wb_hit, dec;

    // Hazards look only at registered counts, so a same-cycle writeback never releases a stall early.
    always_comb begin
        hazard = id_valid &&
                 ((id_use_rs1 && id_rs1 != 5'd0 && cnt_q[id_rs1] != '0) ||
                  (id_use_rs2 && id_rs2 != 5'd0 && cnt_q[id_rs2] != '0) ||
                  (id_regwrite && id_rd != 5'd0 && cnt_q[id_rd] == CNT_MAX));
        issue        = !reset && state_q == RUN && id_valid && !hazard && !ex_flush;
        stall_if_id  = !reset && state_q == RUN && hazard && !ex_flush;
        bubble_id_ex = !issue;
    end

    always_comb begin
        inc    = issue && id_regwrite && id_rd != 5'd0;
        wb_hit = wb_regwrite && wb_rd != 5'd0;
        dec    = wb_hit && cnt_q[wb_rd] != '0;
        cnt_d  = cnt_q;
        for (int r = 1; r < 32; r++) begin
            if (inc && id_rd == 5'(r) && !(dec && wb_rd == 5'(r)))
                cnt_d[r] = cnt_q[r] + CW'(1);
            else if (dec && wb_rd == 5'(r) && !(inc && id_rd == 5'(r)))
                cnt_d[r] = cnt_q[r] - CW'(1);
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < 32; r++)
            pending[r] = cnt_q[r] != '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (ex_flush) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        consec_d       = '0;
        stall_cycles_d = stall_cycles_q;
        if (stall_if_id) begin
            consec_d = (consec_q == SLIMIT) ? consec_q : consec_q + SW'(1);
            if (stall_cycles_q != 32'hFFFF_FFFF)
                stall_cycles_d = stall_cycles_q + 32'd1;
        end
        deadlock_d  = deadlock_q || consec_d == SLIMIT;
        underflow_d = underflow_q || (wb_hit && cnt_q[wb_rd] == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            consec_q       <= '0;
            stall_cycles_q <= '0;
            underflow_q    <= 1'b0;
            deadlock_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            consec_q       <= consec_d;
            stall_cycles_q <= stall_cycles_d;
            underflow_q    <= underflow_d;
            deadlock_q     <= deadlock_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign err_underflow = underflow_q;
    assign err_deadlock  = deadlock_q;
endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Bench for id_scoreboard_ctrl: vector tables through an expectation queue plus hand-written corner sequences.
module tb_id_scoreboard_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, ex_flush, wb_regwrite;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        issue, stall_if_id, bubble_id_ex, err_underflow, err_deadlock;
    logic [31:0] pending, stall_cycles;

    always #5 clock = ~clock;

    id_scoreboard_ctrl #(.MAX_INFLIGHT(3), .STALL_LIMIT(64)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .ex_flush(ex_flush),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .issue(issue), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .pending(pending), .stall_cycles(stall_cycles),
        .err_underflow(err_underflow), .err_deadlock(err_deadlock)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        rw, fl, wbw;
        logic [4:0]  wbrd;
        logic        e_iss, e_stl, e_bub;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tab[$];
    vec_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int v, input int rs1, input int rs2, input int u1, input int u2,
                                input int rd, input int rw, input int fl, input int wbw, input int wbrd,
                                input int iss, input int stl, input int bub, input logic [31:0] pend);
        vec_t r;
        r.valid = v[0];   r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1[0]; r.u2 = u2[0];
        r.rd    = 5'(rd); r.rw = rw[0];    r.fl = fl[0];    r.wbw = wbw[0]; r.wbrd = 5'(wbrd);
        r.e_iss = iss[0]; r.e_stl = stl[0]; r.e_bub = bub[0]; r.e_pend = pend;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regwrite = 0; ex_flush = 0; wb_regwrite = 0; wb_rd = 0;
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        id_rd = v.rd; id_regwrite = v.rw; ex_flush = v.fl; wb_regwrite = v.wbw; wb_rd = v.wbrd;
    endtask

    task automatic run_table(input string tag);
        vec_t e;
        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i]);
            expq.push_back(tab[i]);
            @(negedge clock);
            e = expq.pop_front();
            chk($sformatf("%s[%0d].issue", tag, i), {31'd0, issue}, {31'd0, e.e_iss});
            chk($sformatf("%s[%0d].stall", tag, i), {31'd0, stall_if_id}, {31'd0, e.e_stl});
            chk($sformatf("%s[%0d].bubble", tag, i), {31'd0, bubble_id_ex}, {31'd0, e.e_bub});
            chk($sformatf("%s[%0d].pending", tag, i), pending, e.e_pend);
            @(posedge clock); #1;
        end
        tab.delete();
    endtask

    initial begin
        idle();
        reset = 1;
        id_valid = 1; id_rd = 5; id_regwrite = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst.issue", {31'd0, issue}, 32'd0);
        chk("rst.stall", {31'd0, stall_if_id}, 32'd0);
        chk("rst.bubble", {31'd0, bubble_id_ex}, 32'd1);
        @(posedge clock); #1;
        reset = 0;
        idle();
        chk("rst.pending", pending, 32'd0);
        chk("rst.stall_cycles", stall_cycles, 32'd0);
        chk("rst.err_underflow", {31'd0, err_underflow}, 32'd0);
        chk("rst.err_deadlock", {31'd0, err_deadlock}, 32'd0);

        // dependent issue, x0 rules, WAW saturation
        //             v rs1 rs2 u1 u2 rd rw fl wbw wbrd  iss stl bub pend
        tab.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 32'h0));
        tab.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,  0, 1, 1, 32'h20));
        tab.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 1, 5,  0, 1, 1, 32'h20));
        tab.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,  1, 0, 0, 32'h0));
        tab.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 32'h40));
        tab.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 6,  1, 0, 0, 32'h40));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 32'h0));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h0));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h80));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h80));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 1, 32'h80));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 7,  0, 1, 1, 32'h80));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 7,  1, 0, 0, 32'h80));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h80));
        tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 1, 32'h80));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 1, 32'h80));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 1, 32'h80));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 1, 32'h80));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0));
        run_table("dep");

        // flush over a stalled instruction, ex_flush ignored in FLUSH
        tab.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 32'h0));
        tab.push_back(mk(1, 5, 0, 1, 0, 8, 1, 0, 0, 0,  0, 1, 1, 32'h20));
        tab.push_back(mk(1, 5, 0, 1, 0, 8, 1, 1, 0, 0,  0, 0, 1, 32'h20));
        tab.push_back(mk(1, 5, 0, 1, 0, 8, 1, 1, 0, 0,  0, 0, 1, 32'h20));
        tab.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h20));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 1, 32'h20));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0));
        run_table("flush");
        chk("acc.stall_cycles", stall_cycles, 32'd6);
        chk("acc.err_underflow", {31'd0, err_underflow}, 32'd0);

        // underflow: WB to x9 with nothing in flight
        idle();
        wb_regwrite = 1; wb_rd = 9;
        @(posedge clock); #1;
        idle();
        chk("uf.set", {31'd0, err_underflow}, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chk("uf.sticky", {31'd0, err_underflow}, 32'd1);
        chk("uf.pending", pending, 32'd0);

        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        chk("rst2.stall_cycles", stall_cycles, 32'd0);
        chk("rst2.err_underflow", {31'd0, err_underflow}, 32'd0);

        // deadlock: 40 stalls, a break, then 64 consecutive stalls
        id_valid = 1; id_rd = 4; id_regwrite = 1;
        @(posedge clock); #1;
        id_rd = 0; id_regwrite = 0; id_rs1 = 4; id_use_rs1 = 1;
        #1;
        chk("dl.stall", {31'd0, stall_if_id}, 32'd1);
        repeat (40) @(posedge clock);
        #1;
        id_valid = 0;
        @(posedge clock); #1;
        id_valid = 1;
        repeat (63) @(posedge clock);
        #1;
        chk("dl.before", {31'd0, err_deadlock}, 32'd0);
        chk("dl.cycles63", stall_cycles, 32'd103);
        @(posedge clock); #1;
        chk("dl.set", {31'd0, err_deadlock}, 32'd1);
        chk("dl.cycles64", stall_cycles, 32'd104);

        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        #1;
        chk("rst3.err_deadlock", {31'd0, err_deadlock}, 32'd0);
        chk("rst3.stall_cycles", stall_cycles, 32'd0);
        chk("rst3.issue", {31'd0, issue}, 32'd1);

        // reset while stalled on x3 with two writes in flight
        idle();
        id_valid = 1; id_rd = 3; id_regwrite = 1;
        repeat (2) @(posedge clock);
        #1;
        id_rd = 0; id_regwrite = 0; id_rs1 = 3; id_use_rs1 = 1;
        #1;
        chk("rms.stall", {31'd0, stall_if_id}, 32'd1);
        chk("rms.pending", pending, 32'h8);
        reset = 1;
        #1;
        chk("rms.rst_issue", {31'd0, issue}, 32'd0);
        chk("rms.rst_stall", {31'd0, stall_if_id}, 32'd0);
        chk("rms.rst_bubble", {31'd0, bubble_id_ex}, 32'd1);
        @(posedge clock); #1;
        reset = 0;
        #1;
        chk("rms.pending0", pending, 32'd0);
        chk("rms.issue", {31'd0, issue}, 32'd1);
        chk("rms.bubble", {31'd0, bubble_id_ex}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
